hazard_unit: RTL and testbench

Parametrised data-hazard detector for the 16-bit pipelined core, sitting beside the IF/ID register and driving the PC/IF-ID hold and ID/EX bubble. It compares the source registers of the instruction in IF/ID against the destination registers of NSTAGE downstream pipeline stages and decides to stall through a registered state machine. A watchdog counts consecutive stall cycles and flags a stuck pipeline. Optional forwarding selects reduce stalls to load-use cases only.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_cmp.sv | 34 +++
 rtl/hazard_unit.sv | 134 +++++++++++++
 tb/tb_hazard_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the data-hazard detector.
// Instruction layout: [15:13] op, [12:10] rs, [9:7] rt, [6:4] rd.
package hazard_pkg;

    localparam logic [2:0] OP_RTYPE = 3'd0;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;
    localparam int RS_MSB = 12;
    localparam int RS_LSB = 10;
    localparam int RT_MSB = 9;
    localparam int RT_LSB = 7;
    localparam int RD_MSB = 6;
    localparam int RD_LSB = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Per-stage comparator: picks the stage destination register, decides
// whether the stage really writes (r0 never counts), and matches it
// against the IF/ID source registers.
module hazard_cmp
    import hazard_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int RADDR_W = 3
) (
    input  logic [INSTR_W-1:0] stg_instr_i,
    input  logic               stg_wr_i,
    input  logic               stg_regdst_i,
    input  logic [RADDR_W-1:0] rs_i,
    input  logic [RADDR_W-1:0] rt_i,
    input  logic               reads_rt_i,
    output logic               hit_rs_o,
    output logic               hit_rt_o
);

    logic [RADDR_W-1:0] dest;
    logic               live;

    assign dest     = stg_regdst_i ? stg_instr_i[RD_LSB +: RADDR_W]
                                   : stg_instr_i[RT_LSB +: RADDR_W];
    assign live     = stg_wr_i && (dest != '0);
    assign hit_rs_o = live && (dest == rs_i);
    assign hit_rt_o = live && reads_rt_i && (dest == rt_i);

    // Opcode/rs and low bits of the stage instruction play no part here.
    logic unused_bits;
    assign unused_bits = ^{stg_instr_i[INSTR_W-1:RT_LSB+RADDR_W],
                           stg_instr_i[RD_LSB-1:0]};

endmodule

// File: rtl/hazard_unit.sv
// Data-hazard detector beside the IF/ID register. Registers a stall
// decision, counts consecutive stall cycles and raises a sticky watchdog
// flag when the pipeline stays stalled for MAX_STALL cycles.
// Build option HAZARD_FWD_EN: drive forwarding selects and stall only on
// a load-use hit in stage 0; otherwise every hit stalls and fwd_* stay 0.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int INSTR_W   = 16,
    parameter int RADDR_W   = 3,
    parameter int NSTAGE    = 2,
    parameter int MAX_STALL = 15,
    localparam int CNT_W    = $clog2(MAX_STALL + 1),
    localparam int FWD_W    = $clog2(NSTAGE + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [INSTR_W-1:0]        ifid_instr_i,
    input  logic [NSTAGE*INSTR_W-1:0] stg_instr_i,
    input  logic [NSTAGE-1:0]         stg_wr_i,
    input  logic [NSTAGE-1:0]         stg_regdst_i,
    input  logic [NSTAGE-1:0]         stg_load_i,
    output logic                      stall_o,
    output logic                      bubble_o,
    output logic [CNT_W-1:0]          stall_cnt_o,
    output logic                      stall_err_o,
    output logic [FWD_W-1:0]          fwd_a_o,
    output logic [FWD_W-1:0]          fwd_b_o
);

    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic               reads_rt;
    logic [NSTAGE-1:0]  hit_rs;
    logic [NSTAGE-1:0]  hit_rt;
    logic               need_stall;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    assign rs       = ifid_instr_i[RS_LSB +: RADDR_W];
    assign rt       = ifid_instr_i[RT_LSB +: RADDR_W];
    assign reads_rt = (ifid_instr_i[OP_MSB:OP_LSB] == OP_RTYPE);

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        hazard_cmp #(
            .INSTR_W (INSTR_W),
            .RADDR_W (RADDR_W)
        ) u_cmp (
            .stg_instr_i  (stg_instr_i[g*INSTR_W +: INSTR_W]),
            .stg_wr_i     (stg_wr_i[g]),
            .stg_regdst_i (stg_regdst_i[g]),
            .rs_i         (rs),
            .rt_i         (rt),
            .reads_rt_i   (reads_rt),
            .hit_rs_o     (hit_rs[g]),
            .hit_rt_o     (hit_rt[g])
        );
    end

`ifdef HAZARD_FWD_EN
    logic [FWD_W-1:0] fwd_a_enc;
    logic [FWD_W-1:0] fwd_b_enc;

    // Priority encode matching stages; scanning downwards lets the
    // nearest (newest) stage overwrite older matches.
    always_comb begin
        fwd_a_enc = '0;
        fwd_b_enc = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (hit_rs[i]) fwd_a_enc = FWD_W'(i + 1);
            if (hit_rt[i]) fwd_b_enc = FWD_W'(i + 1);
        end
    end

    // Forwarding covers everything except a load still in ID/EX.
    assign need_stall = (hit_rs[0] || hit_rt[0]) && stg_load_i[0];
    assign fwd_a_o    = reset ? '0 : fwd_a_enc;
    assign fwd_b_o    = reset ? '0 : fwd_b_enc;
`else
    assign need_stall = |{hit_rs, hit_rt};
    assign fwd_a_o    = '0;
    assign fwd_b_o    = '0;

    logic unused_load;
    assign unused_load = ^stg_load_i;
`endif

    logic unused_ifid;
    assign unused_ifid = ^ifid_instr_i[RT_LSB-1:0];

    // State, counter and watchdog registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic plus stall counter and sticky watchdog.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (need_stall) state_d = STALL;
            end
            STALL: begin
                if (!need_stall) state_d = IDLE;
                if (cnt_q == CNT_W'(MAX_STALL)) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // The count only survives while the stall continues; leaving
        // STALL clears it on the same edge that drops stall.
        if (state_q == STALL && state_d == STALL) begin
            if (cnt_q == CNT_W'(MAX_STALL)) cnt_d = cnt_q;
            else                            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stall_o     = reset || (state_q == STALL);
    assign bubble_o    = stall_o;
    assign stall_cnt_o = cnt_q;
    assign stall_err_o = err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: fixed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_hazard_unit;

    localparam int NS = 2;
    localparam int MS = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] ifid;
    logic [31:0] stg;
    logic [1:0]  wr, rd, ld;
    logic        stall, bubble, err;
    logic [3:0]  cnt;
    logic [1:0]  fa, fb;

    hazard_unit #(
        .INSTR_W   (16),
        .RADDR_W   (3),
        .NSTAGE    (NS),
        .MAX_STALL (MS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ifid_instr_i (ifid),
        .stg_instr_i  (stg),
        .stg_wr_i     (wr),
        .stg_regdst_i (rd),
        .stg_load_i   (ld),
        .stall_o      (stall),
        .bubble_o     (bubble),
        .stall_cnt_o  (cnt),
        .stall_err_o  (err),
        .fwd_a_o      (fa),
        .fwd_b_o      (fb)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: whether the unit is stalling, how many consecutive
    // cycles it has stalled, and the sticky error.
    bit m_stall;
    int m_run;
    bit m_err;

    function automatic logic [15:0] mk(int op, int rs, int rt, int rdf);
        return 16'((op << 13) | (rs << 10) | (rt << 7) | (rdf << 4));
    endfunction

    function automatic int dest_of(int s);
        int ins;
        ins = int'((stg >> (16 * s)) & 32'hffff);
        return rd[s] ? (ins >> 4) % 8 : (ins >> 7) % 8;
    endfunction

    function automatic bit hit(int s, bit use_rt);
        int op, rs, rt, d;
        op = int'(ifid) >> 13;
        rs = (int'(ifid) >> 10) % 8;
        rt = (int'(ifid) >> 7) % 8;
        d  = dest_of(s);
        if (!wr[s] || d == 0) return 1'b0;
        return use_rt ? (op == 0 && d == rt) : (d == rs);
    endfunction

    function automatic bit need();
`ifdef HAZARD_FWD_EN
        return (hit(0, 0) || hit(0, 1)) && ld[0];
`else
        for (int s = 0; s < NS; s++)
            if (hit(s, 0) || hit(s, 1)) return 1'b1;
        return 1'b0;
`endif
    endfunction

    function automatic int fwd_exp(bit use_rt);
`ifdef HAZARD_FWD_EN
        if (reset) return 0;
        for (int s = 0; s < NS; s++)
            if (hit(s, use_rt)) return s + 1;
`endif
        return 0;
    endfunction

    function automatic int exp_cnt();
        if (!m_stall) return 0;
        return (m_run - 1 > MS) ? MS : m_run - 1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // One clock: advance the model on the rising edge, compare at falling.
    task automatic step();
        bit nd, ce;
        nd = need();
        ce = m_stall && (exp_cnt() == MS);
        @(posedge clock);
        if (reset) begin
            m_stall = 1'b0;
            m_run   = 0;
            m_err   = 1'b0;
        end else begin
            if (ce) m_err = 1'b1;
            m_run   = nd ? (m_stall ? m_run + 1 : 1) : 0;
            m_stall = nd;
        end
        @(negedge clock);
        chk("stall",  stall,  reset || m_stall);
        chk("bubble", bubble, reset || m_stall);
        chk("cnt",    cnt,    exp_cnt());
        chk("err",    err,    m_err);
        chk("fwd_a",  fa,     fwd_exp(0));
        chk("fwd_b",  fb,     fwd_exp(1));
    endtask

    typedef struct {
        logic [15:0] ifid;
        logic [31:0] stg;
        logic [1:0]  wr, rd, ld;
        bit          e_nofwd, e_fwd;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{mk(0,2,3,0), {mk(0,0,0,0), mk(0,0,0,3)}, 2'b01, 2'b01, 2'b11, 1, 1};
        tbl[1] = '{mk(4,1,5,0), {mk(0,0,5,0), 16'h0},       2'b10, 2'b00, 2'b11, 0, 0};
        tbl[2] = '{mk(0,0,0,0), {16'h0, mk(0,0,0,0)},       2'b01, 2'b01, 2'b11, 0, 0};
        tbl[3] = '{mk(0,2,1,0), {16'h0, mk(0,0,0,2)},       2'b00, 2'b01, 2'b11, 0, 0};
        tbl[4] = '{mk(5,6,0,0), {mk(0,0,6,0), 16'h0},       2'b10, 2'b00, 2'b11, 1, 0};
        tbl[5] = '{mk(0,1,4,0), {mk(0,0,0,4), mk(0,0,4,0)}, 2'b11, 2'b10, 2'b11, 1, 1};
        tbl[6] = '{mk(0,3,1,0), {16'h0, mk(0,0,3,5)},       2'b01, 2'b01, 2'b11, 0, 0};
        tbl[7] = '{mk(0,3,1,0), {16'h0, mk(0,0,3,5)},       2'b01, 2'b00, 2'b11, 1, 1};
        tbl[8] = '{mk(2,7,0,0), {16'h0, mk(0,0,0,7)},       2'b01, 2'b01, 2'b10, 1, 0};

        reset = 1'b1;
        ifid  = '0;
        stg   = '0;
        wr    = '0;
        rd    = '0;
        ld    = '0;
        m_stall = 0; m_run = 0; m_err = 0;
        #1;
        chk("rst_stall", stall, 1);
        chk("rst_bubble", bubble, 1);
        step();
        step();
        chk("rst_cnt", cnt, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        step();
        chk("post_rst_stall", stall, 0);

        // Vector table: each entry held one cycle, stall seen one cycle later.
        for (int i = 0; i < 9; i++) begin
            ifid = tbl[i].ifid;
            stg  = tbl[i].stg;
            wr   = tbl[i].wr;
            rd   = tbl[i].rd;
            ld   = tbl[i].ld;
            step();
`ifdef HAZARD_FWD_EN
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_fwd);
`else
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_nofwd);
`endif
        end

        // Stage-0 hazard then stage moves on.
        ifid = mk(0,2,3,0); stg = {16'h0, mk(0,0,0,3)}; wr = 2'b01; rd = 2'b01; ld = 2'b01;
        step();
        chk("s0_hit_stall", stall, 1);
        wr = 2'b00;
        step();
        chk("s0_clear_stall", stall, 0);
        chk("s0_clear_cnt", cnt, 0);

        // Watchdog: 20 cycles of stage-0 load hit.
        wr = 2'b01;
        for (int i = 0; i < 20; i++) step();
        chk("wd_cnt_sat", cnt, MS);
        chk("wd_err", err, 1);
        wr = 2'b00;
        step();
        chk("wd_clear_stall", stall, 0);
        chk("wd_clear_cnt", cnt, 0);
        step();
        step();
        chk("wd_err_sticky", err, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("wd_err_reset", err, 0);

        // Reset asserted while stalled.
        wr = 2'b01;
        step();
        step();
        chk("mid_stall_on", stall, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_stall", stall, 1);
        chk("mid_rst_bubble", bubble, 1);
        chk("mid_rst_fwd_a", fa, 0);
        chk("mid_rst_fwd_b", fb, 0);
        step();
        reset = 1'b0;
        wr = 2'b00;
        step();
        chk("mid_after_stall", stall, 0);
        chk("mid_after_cnt", cnt, 0);
        chk("mid_after_err", err, 0);

        // Forwarding corner cases (stall everywhere without forwarding).
        ifid = mk(4,3,0,0); stg = {mk(0,0,3,0), mk(0,0,0,0)}; wr = 2'b10; rd = 2'b00; ld = 2'b00;
        #1;
`ifdef HAZARD_FWD_EN
        chk("fwd_s1_a", fa, 2);
`else
        chk("fwd_s1_a", fa, 0);
`endif
        step();
`ifdef HAZARD_FWD_EN
        chk("fwd_s1_stall", stall, 0);
`else
        chk("fwd_s1_stall", stall, 1);
`endif
        ifid = mk(0,1,6,0); stg = {16'h0, mk(0,0,0,6)}; wr = 2'b01; rd = 2'b01; ld = 2'b01;
        step();
        chk("loaduse_stall", stall, 1);
`ifdef HAZARD_FWD_EN
        chk("loaduse_fwd_b", fb, 1);
`else
        chk("loaduse_fwd_b", fb, 0);
`endif

        // Randomized traffic with a small register range to provoke hits.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            ifid  = mk(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7))
                    | 16'($urandom_range(0, 15));
            stg   = {mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3)),
                     mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3))};
            wr    = 2'($urandom_range(0, 3));
            rd    = 2'($urandom_range(0, 3));
            ld    = 2'($urandom_range(0, 3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
